// File: rtl/btn_dir_conditioner.sv
// Button/direction front end for the snake game: syncs the divider square waves into
// clk_in enables, debounces the direction buttons and commits a no-reversal direction per step.

module btn_debounce_lane #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk_in,
  input  logic reset,
  input  logic deb_en,
  input  logic sample,
  output logic level,
  output logic press
);
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             at_stable;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign at_stable = (cnt_inc == CNT_W'(STABLE_CNT));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      level <= (nxt == PRESSED) || (nxt == RELEASE_WAIT);
      press <= (state == PRESS_WAIT) && (nxt == PRESSED);
    end
  end

  // The FSM only moves on a debounce sample; every other cycle holds.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if (deb_en) begin
      case (state)
        IDLE: if (sample) begin
          nxt     = PRESS_WAIT;
          cnt_nxt = CNT_W'(1);
        end
        PRESS_WAIT: if (sample) begin
          if (at_stable) begin
            nxt     = PRESSED;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
        PRESSED: if (!sample) begin
          nxt     = RELEASE_WAIT;
          cnt_nxt = CNT_W'(1);
        end
        RELEASE_WAIT: if (!sample) begin
          if (at_stable) begin
            nxt     = IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          nxt     = PRESSED;
          cnt_nxt = '0;
        end
        default: begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end
endmodule

module btn_dir_conditioner #(
  parameter int NBTN       = 4,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            clk_debounce,
  input  logic            clk_snake,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [1:0]      dir,
  output logic            dir_pending,
  output logic            step
);
  logic [NBTN-1:0] btn_s1, btn_s2;
  logic            deb_s1, deb_s2, deb_d;
  logic            snk_s1, snk_s2, snk_d;
  logic            deb_en, snk_en;
  logic [1:0]      pend_dir, eff_dir, cand_dir;
  logic            cand_vld, accept;

  // Divider outputs are plain data here: synchronize, then detect rising edges.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb_s1 <= 1'b0;
      deb_s2 <= 1'b0;
      deb_d  <= 1'b0;
      snk_s1 <= 1'b0;
      snk_s2 <= 1'b0;
      snk_d  <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      deb_s1 <= clk_debounce;
      deb_s2 <= deb_s1;
      deb_d  <= deb_s2;
      snk_s1 <= clk_snake;
      snk_s2 <= snk_s1;
      snk_d  <= snk_s2;
    end
  end

  assign deb_en = deb_s2 & ~deb_d;
  assign snk_en = snk_s2 & ~snk_d;

  for (genvar g = 0; g < NBTN; g++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_CNT(STABLE_CNT),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk_in(clk_in),
      .reset (reset),
      .deb_en(deb_en),
      .sample(btn_s2[g]),
      .level (btn_level[g]),
      .press (btn_press[g])
    );
  end

  // Lowest set index wins; scanning downward leaves it as the last writer.
  always_comb begin
    cand_vld = 1'b0;
    cand_dir = 2'b00;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (btn_press[i]) begin
        cand_vld = 1'b1;
        cand_dir = 2'(i);
      end
    end
  end

  // Same or opposite direction shares bit 1 (up/down vs left/right axis).
  assign eff_dir = dir_pending ? pend_dir : dir;
  assign accept  = cand_vld && (cand_dir[1] != eff_dir[1]);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      dir         <= 2'b11;
      pend_dir    <= 2'b00;
      dir_pending <= 1'b0;
      step        <= 1'b0;
    end else begin
      step <= snk_en;
      if (snk_en && dir_pending) dir <= pend_dir;
      if (accept) begin
        pend_dir    <= cand_dir;
        dir_pending <= 1'b1;
      end else if (snk_en) begin
        dir_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_btn_dir_conditioner.sv
// Bench for btn_dir_conditioner: directed scenarios plus random button/step traffic
// checked against a run-length debounce and pending-request direction model.

module tb_btn_dir_conditioner;
  localparam int STABLE = 4;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       clk_debounce = 1'b0;
  logic       clk_snake = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level, btn_press;
  logic [1:0] dir;
  logic       dir_pending, step;

  btn_dir_conditioner #(.NBTN(4), .STABLE_CNT(STABLE), .CNT_W(3)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .clk_debounce(clk_debounce),
    .clk_snake   (clk_snake),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .dir         (dir),
    .dir_pending (dir_pending),
    .step        (step)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_chk  = 0;

  // observed values captured by tick
  logic [3:0] o_press, o_level, o_press2;
  logic [1:0] o_dir;
  logic       o_pend, o_step, o_step_pre;

  // reference model
  int         m_run[4];
  logic [3:0] m_level;
  logic [1:0] m_dir, m_pdir;
  bit         m_pv;
  logic [3:0] exp_press, exp_level;
  logic [1:0] exp_dir;
  logic       exp_pend, exp_step;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_level = 4'b0000;
    m_dir   = 2'b11;
    m_pdir  = 2'b00;
    m_pv    = 1'b0;
  endfunction

  function automatic void model_tick(input logic [3:0] b, input bit d, input bit s);
    int cand;
    logic [1:0] eff;
    exp_press = 4'b0000;
    if (d) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE) begin
            m_level[i] = b[i];
            m_run[i]   = 0;
            if (b[i]) exp_press[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    exp_level = m_level;
    if (s && m_pv) begin
      m_dir = m_pdir;
      m_pv  = 1'b0;
    end
    if (exp_press != 4'b0000) begin
      cand = 0;
      while (!exp_press[cand]) cand++;
      eff = m_pv ? m_pdir : m_dir;
      if (cand / 2 != int'(eff) / 2) begin
        m_pdir = 2'(cand);
        m_pv   = 1'b1;
      end
    end
    exp_dir  = m_dir;
    exp_pend = m_pv;
    exp_step = s;
  endfunction

  // One debounce sample (d) and/or one snake step (s). The snake edge is launched so
  // that its enable lands in the same cycle as any resulting btn_press.
  task automatic tick(input logic [3:0] b, input bit d, input bit s);
    @(negedge clk_in);
    btn_raw = b;
    repeat (2) @(negedge clk_in);
    if (d) clk_debounce = 1'b1;
    @(negedge clk_in);
    if (s) clk_snake = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    o_press = btn_press; o_level = btn_level; o_step_pre = step;
    @(negedge clk_in);
    o_step = step; o_dir = dir; o_pend = dir_pending; o_press2 = btn_press;
    clk_debounce = 1'b0;
    clk_snake    = 1'b0;
    model_tick(b, d, s);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1; btn_raw = 4'b0000; clk_debounce = 1'b0; clk_snake = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 4'($urandom); clk_debounce = ~clk_debounce; clk_snake = ~clk_snake;
      @(negedge clk_in);
    end
    n_chk++; if (btn_level !== 4'b0000) $display("FAIL reset_level: got %b want 0000", btn_level); else n_pass++;
    n_chk++; if (btn_press !== 4'b0000) $display("FAIL reset_press: got %b want 0000", btn_press); else n_pass++;
    n_chk++; if (dir !== 2'b11) $display("FAIL reset_dir: got %b want 11", dir); else n_pass++;
    n_chk++; if (dir_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", dir_pending); else n_pass++;
    n_chk++; if (step !== 1'b0) $display("FAIL reset_step: got %b want 0", step); else n_pass++;
    do_reset();
    // abort a half-counted press; a fresh run of STABLE samples is then required
    tick(4'b0001, 1, 0);
    tick(4'b0001, 1, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(4'b0001, 1, 0);
      n_chk++;
      if (o_press !== ((i == 4) ? 4'b0001 : 4'b0000))
        $display("FAIL reset_midwait_press[%0d]: got %b", i, o_press);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(4'b0001, 1, 0);
      n_chk++; if (o_press !== ((i == 4) ? 4'b0001 : 4'b0000)) $display("FAIL clean_press[%0d]: got %b", i, o_press); else n_pass++;
      n_chk++; if (o_level !== ((i == 4) ? 4'b0001 : 4'b0000)) $display("FAIL clean_level[%0d]: got %b", i, o_level); else n_pass++;
    end
    n_chk++; if (o_press2 !== 4'b0000) $display("FAIL clean_pulse_width: got %b want 0000", o_press2); else n_pass++;
    n_chk++; if (o_pend !== 1'b1) $display("FAIL clean_up_accepted: got %b want 1", o_pend); else n_pass++;
    tick(4'b0001, 1, 0);
    n_chk++; if (o_press !== 4'b0000 || o_level !== 4'b0001) $display("FAIL clean_hold: press %b level %b want 0000 0001", o_press, o_level); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      tick(4'b0000, 1, 0);
      n_chk++; if (o_level !== ((i == 4) ? 4'b0000 : 4'b0001)) $display("FAIL release_level[%0d]: got %b", i, o_level); else n_pass++;
      n_chk++; if (o_press !== 4'b0000) $display("FAIL release_press[%0d]: got %b want 0000", i, o_press); else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b1111_0111;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick({1'b0, pat[i], 2'b00}, 1, 0);
      n_chk++; if (o_press !== ((i == 7) ? 4'b0100 : 4'b0000)) $display("FAIL bounce_press[%0d]: got %b", i, o_press); else n_pass++;
    end
    n_chk++; if (o_level !== 4'b0100) $display("FAIL bounce_level: got %b want 0100", o_level); else n_pass++;
  endtask

  task automatic test_reversal();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(4'b0100, 1, 0);
    n_chk++; if (o_press !== 4'b0100 || o_pend !== 1'b0) $display("FAIL reversal_left: press %b pend %b want 0100 0", o_press, o_pend); else n_pass++;
    for (int i = 1; i <= 4; i++) tick(4'b0101, 1, 0);
    n_chk++; if (o_press !== 4'b0001 || o_pend !== 1'b1 || o_dir !== 2'b11) $display("FAIL reversal_up: press %b pend %b dir %b want 0001 1 11", o_press, o_pend, o_dir); else n_pass++;
    tick(4'b0101, 0, 1);
    n_chk++; if (o_step_pre !== 1'b0) $display("FAIL step_early: got %b want 0", o_step_pre); else n_pass++;
    n_chk++; if (o_step !== 1'b1 || o_dir !== 2'b00 || o_pend !== 1'b0) $display("FAIL reversal_commit: step %b dir %b pend %b want 1 00 0", o_step, o_dir, o_pend); else n_pass++;
  endtask

  task automatic test_overwrite_same_cycle();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(4'b0001, 1, 0);
    for (int i = 1; i <= 4; i++) tick(4'b0011, 1, 0);
    n_chk++; if (o_press !== 4'b0010 || o_pend !== 1'b1 || o_dir !== 2'b11) $display("FAIL down_vs_pending_up: press %b pend %b dir %b want 0010 1 11", o_press, o_pend, o_dir); else n_pass++;
    for (int i = 1; i <= 3; i++) tick(4'b0111, 1, 0);
    tick(4'b0111, 1, 1);
    n_chk++; if (o_press !== 4'b0100 || o_step !== 1'b1) $display("FAIL same_cycle_events: press %b step %b want 0100 1", o_press, o_step); else n_pass++;
    n_chk++; if (o_dir !== 2'b00 || o_pend !== 1'b1) $display("FAIL same_cycle_commit: dir %b pend %b want 00 1", o_dir, o_pend); else n_pass++;
    tick(4'b0111, 0, 1);
    n_chk++; if (o_dir !== 2'b10 || o_pend !== 1'b0) $display("FAIL same_cycle_left: dir %b pend %b want 10 0", o_dir, o_pend); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(4'b0010, 1, 0);
    tick(4'b0010, 0, 1);
    n_chk++; if (o_dir !== 2'b01) $display("FAIL simul_setup_dir: got %b want 01", o_dir); else n_pass++;
    for (int i = 1; i <= 4; i++) tick(4'b0000, 1, 0);
    for (int i = 1; i <= 4; i++) tick(4'b1001, 1, 0);
    n_chk++; if (o_press !== 4'b1001 || o_pend !== 1'b0) $display("FAIL simul_priority: press %b pend %b want 1001 0", o_press, o_pend); else n_pass++;
    tick(4'b1001, 0, 1);
    n_chk++; if (o_dir !== 2'b01 || o_step !== 1'b1) $display("FAIL simul_no_commit: dir %b step %b want 01 1", o_dir, o_step); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] cur;
    bit d, s;
    cur = 4'b0000;
    do_reset();
    for (int n = 0; n < 160; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
      d = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 3) == 0);
      tick(cur, d, s);
      n_chk++; if (o_press !== exp_press) $display("FAIL rnd_press[%0d]: got %b want %b", n, o_press, exp_press); else n_pass++;
      n_chk++; if (o_level !== exp_level) $display("FAIL rnd_level[%0d]: got %b want %b", n, o_level, exp_level); else n_pass++;
      n_chk++; if (o_press2 !== 4'b0000 || o_step_pre !== 1'b0) $display("FAIL rnd_pulse[%0d]: press %b step %b want 0000 0", n, o_press2, o_step_pre); else n_pass++;
      n_chk++; if (o_step !== exp_step) $display("FAIL rnd_step[%0d]: got %b want %b", n, o_step, exp_step); else n_pass++;
      n_chk++; if (o_dir !== exp_dir) $display("FAIL rnd_dir[%0d]: got %b want %b", n, o_dir, exp_dir); else n_pass++;
      n_chk++; if (o_pend !== exp_pend) $display("FAIL rnd_pending[%0d]: got %b want %b", n, o_pend, exp_pend); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_reversal();
    test_overwrite_same_cycle();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/btn_dir_conditioner.md
Name: btn_dir_conditioner

Overview:
- Consumer end of the clock-divider outputs. It takes the divider's clk_debounce and clk_snake square waves as data inputs, synchronizes them, and turns their rising edges into single-cycle enables in the clk_in domain.
- Debounces four direction push-buttons and produces clean levels and one-cycle press pulses.
- Holds a pending direction request with a no-reversal rule. That request is committed to the snake direction register on each clk_snake rising edge.
- Sits between the board buttons plus divider and the snake movement logic.

Parameters:
- NBTN, 4, number of buttons; fixed order [0]=up, [1]=down, [2]=left, [3]=right.
- STABLE_CNT, 4, number of consecutive identical debounce samples needed to change a button state (legal range 2..7).
- CNT_W, 3, width of each per-button sample counter; must hold STABLE_CNT.

Ports:
- clk_in  input  1  system clock; the only clock in the block.
- reset  input  1  asynchronous, active-high reset.
- clk_debounce  input  1  debounce square wave from the divider; treated as data, never used as a clock.
- clk_snake  input  1  game-step square wave from the divider; treated as data.
- btn_raw  input  NBTN  raw asynchronous button inputs, active-high.
- btn_level  output  NBTN  debounced button level.
- btn_press  output  NBTN  one-cycle pulse on each debounced press.
- dir  output  2  current snake direction: 00 up, 01 down, 10 left, 11 right.
- dir_pending  output  1  high while an accepted request is waiting to be committed.
- step  output  1  one-cycle pulse on each clk_snake rising edge; dir is already updated in that cycle.

Behaviour:
- Reset: asynchronous, active-high, clears every flop.
  - btn_level=0, btn_press=0, dir=11 (right), dir_pending=0, step=0.
  - All per-button FSMs go to IDLE, all counters to 0, all synchronizer and edge-detect flops to 0.
  - Assertion mid-operation aborts everything immediately. After release the block behaves exactly as from power-up.
- Synchronization: btn_raw, clk_debounce and clk_snake each pass through a 2-flop synchronizer.
- Edge detection:
  - deb_en = sync_deb & ~deb_d, where deb_d is the delayed copy.
  - snk_en = sync_snk & ~snk_d.
  - Each enable is high for exactly one clk_in cycle per source rising edge.
- Per-button FSM: states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The FSM advances only in cycles with deb_en=1 and holds otherwise.
  - IDLE: sample=1 -> PRESS_WAIT, cnt=1. Sample=0 -> stay.
  - PRESS_WAIT:
    - Sample=1 -> cnt+1. When cnt+1 reaches STABLE_CNT -> PRESSED, cnt=0.
    - Sample=0 -> IDLE, cnt=0.
  - PRESSED: sample=0 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT:
    - Sample=0 -> cnt+1. When cnt+1 reaches STABLE_CNT -> IDLE, cnt=0.
    - Sample=1 -> PRESSED, cnt=0.
  - btn_level=1 in PRESSED and RELEASE_WAIT, else 0. It is registered and changes in the cycle after the deciding deb_en.
  - btn_press is high exactly one cycle, in the same cycle btn_level rises on a PRESS_WAIT->PRESSED transition. There is no pulse on release.
- Direction logic:
  - eff_dir = dir_pending ? pend_dir : dir.
  - Candidate: the lowest-index bit set in btn_press (priority up > down > left > right).
  - The candidate is rejected if it equals eff_dir or is the opposite of eff_dir (up<->down, left<->right).
  - An accepted candidate sets pend_dir=candidate and dir_pending=1. A later accepted candidate overwrites an earlier one.
- Commit on snk_en:
  - If dir_pending=1, then dir<=pend_dir and dir_pending<=0.
  - step<=1 for one cycle, whether or not a commit happened.
- Simultaneous btn_press and snk_en in the same cycle:
  - The old pending request commits.
  - The candidate is checked against eff_dir, which equals the value being committed. If accepted, it becomes the new pending request with dir_pending=1.
  - This guarantees that no two consecutive committed directions are opposite.
- Latency:
  - btn_raw to first sample is at most 2 cycles of sync plus the wait for the next deb_en.
  - Press is declared at the STABLE_CNT-th consecutive high sample; outputs follow 1 cycle after that deb_en.
  - clk_snake rising edge to step/dir update is 3 cycles (2 sync + 1 edge register).

Test Plan:
- Reset: hold reset for 5 cycles with all inputs toggling -> all outputs 0 except dir=11. Assert reset mid-PRESS_WAIT -> counter cleared; after release, a fresh 4 high samples are needed.
- Clean press, clk_debounce period 8 cycles, btn_raw[0]=1 held -> btn_press[0] pulses once, btn_level[0]=1 after the 4th deb_en. Release -> btn_level[0]=0 after 4 low samples, with no further btn_press.
- Bounce: btn_raw[2] high for 3 samples, low for 1, then high for 4 -> exactly one btn_press[2], at the 4th sample of the final run.
- Reversal: dir=11, press left -> rejected, dir_pending stays 0. Press up -> dir_pending=1. Then on a clk_snake edge -> dir=00 and step pulses, 3 cycles after the edge.
- Overwrite and same-cycle: dir=11, pending=up; press down -> rejected against eff_dir=up. Force a press of left in the same cycle as snk_en -> dir=00, pending=left, dir_pending=1.
- Simultaneous presses: up and right released to PRESSED in the same deb_en -> candidate=up (priority). With dir=01 it is rejected, and right is not considered.
